ffe_coeff_bank: RTL and testbench

- Coefficient storage for the FFE; it is the memory end of the adaptation engine's weight interface.
- Drives the current coefficient vector to the FIR and to both adapters, and commits the engine's new coefficient vector when update is enabled.
- Also provides a host single-tap read/write port with handshake, a freeze control, a sequential re-initialisation sweep and an update counter.

---
 rtl/coeff_pkg.sv | 25 ++
 rtl/ffe_coeff_bank_if.sv | 36 +++
 rtl/ffe_coeff_bank.sv | 132 +++++++++++++
 tb/tb_ffe_coeff_bank.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_pkg.sv
// FFE coefficient bank shared definitions.
// Default geometry, state encoding and the unity-tap helper.
package coeff_pkg;

  localparam int FFE_LEN    = 21;
  localparam int NB         = 8;
  localparam int NBF        = 7;
  localparam int CENTER_TAP = 10;
  localparam int ADDR_W     = 5;

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_e;

  // Unity in the coefficient format, clipped to the largest positive code.
  function automatic int def_center(int nb, int nbf);
    int one;
    int top;
    one = 1 << nbf;
    top = (1 << (nb - 1)) - 1;
    return (one < top) ? one : top;
  endfunction

endpackage

// File: rtl/ffe_coeff_bank_if.sv
// Host single-tap read/write port of the FFE coefficient bank.
// Request is held until the one-cycle ack pulse.
interface ffe_coeff_bank_if #(
  parameter int ADDR_W = 5,
  parameter int NB     = 8
) ();

  logic              i_host_req;
  logic              i_host_we;
  logic [ADDR_W-1:0] i_host_addr;
  logic [NB-1:0]     i_host_wdata;
  logic              o_host_ack;
  logic [NB-1:0]     o_host_rdata;
  logic              o_host_err;

  modport master (
    output i_host_req,
    output i_host_we,
    output i_host_addr,
    output i_host_wdata,
    input  o_host_ack,
    input  o_host_rdata,
    input  o_host_err
  );

  modport slave (
    input  i_host_req,
    input  i_host_we,
    input  i_host_addr,
    input  i_host_wdata,
    output o_host_ack,
    output o_host_rdata,
    output o_host_err
  );

endinterface

// File: rtl/ffe_coeff_bank.sv
// FFE coefficient store: adaptation commits, host tap port,
// freeze, sequential re-init sweep and a saturating commit counter.
module ffe_coeff_bank #(
  parameter int FFE_LEN    = coeff_pkg::FFE_LEN,
  parameter int NB         = coeff_pkg::NB,
  parameter int NBF        = coeff_pkg::NBF,
  parameter int CENTER_TAP = coeff_pkg::CENTER_TAP,
  parameter int ADDR_W     = coeff_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_init,
  input  logic                  i_freeze,
  input  logic                  i_update_en,
  input  logic [FFE_LEN*NB-1:0] i_new_coeff,
  output logic [FFE_LEN*NB-1:0] o_coeff_flat,
  ffe_coeff_bank_if.slave       host,
  output logic [31:0]           o_update_count,
  output logic                  o_busy
);

  import coeff_pkg::*;

  localparam logic [NB-1:0] CVAL =
    NB'(def_center(NB, NBF));
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FFE_LEN - 1);

  function automatic logic [NB-1:0] def_tap(int k);
    return (k == CENTER_TAP) ? CVAL : '0;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] widx;
  logic [NB-1:0]     tap_q [FFE_LEN];
  logic [NB-1:0]     tap_d [FFE_LEN];
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [NB-1:0]     rdata_q, rdata_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              commit;
  logic              accept;
  logic              bad;

  always_comb begin
    bad    = 32'(host.i_host_addr) >= FFE_LEN;
    commit = (state_q == RUN) && i_update_en
             && !i_freeze;
    accept = (state_q == RUN) && host.i_host_req
             && !ack_q;
    // A re-init pulse mid-sweep rewrites tap 0 in the same cycle.
    widx    = i_init ? '0 : idx_q;
    state_d = state_q;
    idx_d   = idx_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    ack_d   = accept;
    err_d   = accept && bad;
    rdata_d = '0;

    unique case (state_q)
      RUN: begin
        if (i_init) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      INIT: begin
        if (widx == LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = widx + ADDR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    for (int k = 0; k < FFE_LEN; k++) begin
      if (state_q == INIT) begin
        if (widx == ADDR_W'(k))
          tap_d[k] = def_tap(k);
      end else begin
        if (commit)
          tap_d[k] = i_new_coeff[k*NB +: NB];
        // Host write lands after the commit so it wins its tap.
        if (accept && host.i_host_addr == ADDR_W'(k)) begin
          if (host.i_host_we)
            tap_d[k] = host.i_host_wdata;
          else
            rdata_d = tap_q[k];
        end
      end
    end

    if (commit && cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      idx_q   <= '0;
      for (int k = 0; k < FFE_LEN; k++)
        tap_q[k] <= def_tap(k);
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tap_q   <= tap_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < FFE_LEN; g++) begin : g_flat
    assign o_coeff_flat[g*NB +: NB] = tap_q[g];
  end

  assign host.o_host_ack   = ack_q;
  assign host.o_host_err   = err_q;
  assign host.o_host_rdata = rdata_q;
  assign o_update_count    = cnt_q;
  assign o_busy            = (state_q == INIT);

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// Self-checking bench for ffe_coeff_bank: commit table,
// host scoreboard and re-init / reset corner sequences.
module tb_ffe_coeff_bank;

  import coeff_pkg::*;

  localparam int W = FFE_LEN * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         freeze = 1'b0;
  logic         upd = 1'b0;
  logic [W-1:0] newc = '0;
  logic [W-1:0] coeff;
  logic [31:0]  cnt;
  logic         busy;

  ffe_coeff_bank_if #(.ADDR_W(ADDR_W), .NB(NB)) hif ();

  ffe_coeff_bank dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_init         (init),
    .i_freeze       (freeze),
    .i_update_en    (upd),
    .i_new_coeff    (newc),
    .o_coeff_flat   (coeff),
    .host           (hif.slave),
    .o_update_count (cnt),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [7:0] val;
    logic       up;
    logic       fz;
    logic [7:0] exp;
    int         ecnt;
  } vec_t;

  rsp_t       sb[$];
  vec_t       tbl[7];
  logic [7:0] mdl[FFE_LEN];
  int         nerr = 0;
  int         nchk = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mflat();
    logic [W-1:0] r;
    for (int k = 0; k < FFE_LEN; k++)
      r[k*NB +: NB] = mdl[k];
    return r;
  endfunction

  function automatic logic [W-1:0] rep(logic [7:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < FFE_LEN; k++)
      r[k*NB +: NB] = v;
    return r;
  endfunction

  function automatic logic [7:0] defv(int k);
    return (k == 10) ? 8'h7F : 8'h00;
  endfunction

  task automatic set_all(input logic [7:0] v);
    for (int k = 0; k < FFE_LEN; k++)
      mdl[k] = v;
  endtask

  task automatic set_def();
    for (int k = 0; k < FFE_LEN; k++)
      mdl[k] = defv(k);
  endtask

  task automatic host_start(input logic we,
                            input logic [4:0] a,
                            input logic [7:0] d,
                            input logic [7:0] er,
                            input logic ee);
    rsp_t r;
    r.rdata = er;
    r.err   = ee;
    sb.push_back(r);
    hif.i_host_req   = 1'b1;
    hif.i_host_we    = we;
    hif.i_host_addr  = a;
    hif.i_host_wdata = d;
  endtask

  task automatic host_wait(input int exp_w,
                           input bit hold);
    int   w;
    rsp_t r;
    w = 0;
    while (!hif.o_host_ack && w < 40) begin
      tick();
      w++;
    end
    if (!hif.o_host_ack) begin
      nchk++;
      nerr++;
      $display("FAIL host_timeout: no ack in %0d cycles", w);
      if (sb.size() > 0)
        void'(sb.pop_front());
      hif.i_host_req = 1'b0;
      tick();
      return;
    end
    r = sb.pop_front();
    chk("host_rdata", W'(hif.o_host_rdata), W'(r.rdata));
    chk("host_err", W'(hif.o_host_err), W'(r.err));
    chk("host_latency", W'(w), W'(exp_w));
    if (hold) begin
      tick();
      chk("no_reaccept", W'(hif.o_host_ack), '0);
    end
    hif.i_host_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int g;
    hif.i_host_req   = 1'b0;
    hif.i_host_we    = 1'b0;
    hif.i_host_addr  = '0;
    hif.i_host_wdata = '0;
    tbl[0] = '{8'h11, 1'b1, 1'b0, 8'h11, 2};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 3};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 4};
    tbl[3] = '{8'h44, 1'b1, 1'b1, 8'h11, 4};
    tbl[4] = '{8'h44, 1'b1, 1'b1, 8'h11, 4};
    tbl[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 5};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 8'h80, 5};

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    set_def();
    chk("reset_coeff", coeff, mflat());
    chk("reset_count", W'(cnt), '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_ack", W'(hif.o_host_ack), '0);
    chk("reset_err", W'(hif.o_host_err), '0);
    chk("reset_rdata", W'(hif.o_host_rdata), '0);

    newc = rep(8'h33);
    upd  = 1'b1;
    host_start(1'b0, 5'd10, 8'h00, 8'h7F, 1'b0);
    tick();
    upd = 1'b0;
    set_all(8'h33);
    host_wait(0, 1'b0);
    chk("rd_commit_coeff", coeff, mflat());
    chk("rd_commit_count", W'(cnt), W'(32'd1));

    host_start(1'b0, 5'd25, 8'h00, 8'h00, 1'b1);
    tick();
    host_wait(0, 1'b1);
    host_start(1'b1, 5'd21, 8'hFF, 8'h00, 1'b1);
    tick();
    host_wait(0, 1'b0);
    chk("bad_addr_coeff", coeff, mflat());
    chk("bad_addr_count", W'(cnt), W'(32'd1));

    host_start(1'b1, 5'd20, 8'h5C, 8'h00, 1'b0);
    tick();
    host_wait(0, 1'b0);
    mdl[20] = 8'h5C;
    chk("wr_last_coeff", coeff, mflat());
    host_start(1'b0, 5'd20, 8'h00, 8'h5C, 1'b0);
    tick();
    host_wait(0, 1'b0);
    host_start(1'b0, 5'd0, 8'h00, 8'h33, 1'b0);
    tick();
    host_wait(0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      newc   = rep(tbl[i].val);
      upd    = tbl[i].up;
      freeze = tbl[i].fz;
      tick();
      chk($sformatf("tbl%0d_coeff", i),
          coeff, rep(tbl[i].exp));
      chk($sformatf("tbl%0d_count", i),
          W'(cnt), W'(tbl[i].ecnt));
    end
    upd    = 1'b0;
    freeze = 1'b0;
    set_all(8'h80);

    newc = rep(8'h22);
    upd  = 1'b1;
    host_start(1'b1, 5'd4, 8'hA5, 8'h00, 1'b0);
    tick();
    upd = 1'b0;
    set_all(8'h22);
    mdl[4] = 8'hA5;
    host_wait(0, 1'b0);
    chk("collide_coeff", coeff, mflat());
    chk("collide_count", W'(cnt), W'(32'd6));

    init = 1'b1;
    tick();
    init = 1'b0;
    newc = rep(8'h99);
    upd  = 1'b1;
    for (int c = 0; c < FFE_LEN; c++) begin
      chk($sformatf("sweep%0d_busy", c), W'(busy), W'(1));
      if (c == 5)
        host_start(1'b0, 5'd10, 8'h00, 8'h7F, 1'b0);
      if (c >= 5)
        chk($sformatf("sweep%0d_noack", c),
            W'(hif.o_host_ack), '0);
      tick();
      mdl[c] = defv(c);
      chk($sformatf("sweep%0d_coeff", c), coeff, mflat());
    end
    upd = 1'b0;
    chk("sweep_done_busy", W'(busy), '0);
    chk("sweep_done_noack", W'(hif.o_host_ack), '0);
    host_wait(1, 1'b0);
    chk("sweep_count", W'(cnt), W'(32'd6));

    newc = rep(8'h66);
    upd  = 1'b1;
    tick();
    upd = 1'b0;
    chk("pre_rst_count", W'(cnt), W'(32'd7));
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (7) tick();
    hif.i_host_req   = 1'b1;
    hif.i_host_we    = 1'b1;
    hif.i_host_addr  = 5'd3;
    hif.i_host_wdata = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    set_def();
    chk("midrst_coeff", coeff, mflat());
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_count", W'(cnt), '0);
    chk("midrst_ack", W'(hif.o_host_ack), '0);
    hif.i_host_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ack1", W'(hif.o_host_ack), '0);
    tick();
    chk("midrst_ack2", W'(hif.o_host_ack), '0);
    chk("midrst_coeff2", coeff, mflat());

    init = 1'b1;
    tick();
    init = 1'b0;
    b = 0;
    g = 0;
    while (busy && g < 100) begin
      init = (b == 10);
      tick();
      b++;
      g++;
    end
    init = 1'b0;
    chk("restart_busy_cycles", W'(b), W'(31));
    chk("restart_coeff", coeff, mflat());

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
